list_walk_arb: RTL

- Shares one linked-list pointer walker between N_REQ start-pointer requesters.
- Arbitrates requesters round-robin, then walks the list from the granted start pointer through an internal next-pointer table.
- Emits one pointer per beat on a valid/ready output stream, tagged with requester id and a last flag.
- Sits between request generators and downstream pointer consumers; the table is configured through a write port.

---
 rtl/list_walk_arb_if.sv | 30 +++
 rtl/list_walk_arb.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/list_walk_arb_if.sv
// Request, table-write and pointer-stream signals for list_walk_arb.
// master = request/consumer side, slave = the walker.
interface list_walk_arb_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W_PTR = 4,
    parameter int unsigned W_ID  = 2
);
    logic [N_REQ*W_PTR-1:0] req_start;
    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ-1:0]       req_rdy;
    logic                   tbl_we;
    logic [W_PTR-1:0]       tbl_addr;
    logic [W_PTR-1:0]       tbl_data;
    logic [W_PTR-1:0]       out_ptr;
    logic [W_ID-1:0]        out_id;
    logic                   out_last;
    logic                   out_vld;
    logic                   out_rdy;
    logic                   err_loop;

    modport master (
        output req_start, req_vld, tbl_we, tbl_addr, tbl_data, out_rdy,
        input  req_rdy, out_ptr, out_id, out_last, out_vld, err_loop
    );

    modport slave (
        input  req_start, req_vld, tbl_we, tbl_addr, tbl_data, out_rdy,
        output req_rdy, out_ptr, out_id, out_last, out_vld, err_loop
    );
endinterface

// File: rtl/list_walk_arb.sv
// Round-robin arbiter sharing one linked-list walker among N_REQ requesters.
// Build option LIST_WALK_B2B_EN: grant the next walk on the final-beat handshake.
module list_walk_arb #(
    parameter int unsigned N     = 16,
    parameter int unsigned W_PTR = $clog2(N),
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W_ID  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input logic            clk,
    input logic            rst_n,
    list_walk_arb_if.slave bus
);
    localparam int unsigned W_CNT = $clog2(N + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [W_ID-1:0]    rr_q, rr_d;
    logic [W_PTR-1:0]   tbl_q [N];
    logic [W_PTR-1:0]   tbl_d [N];
    logic               out_vld_q, out_vld_d;
    logic [W_PTR-1:0]   out_ptr_q, out_ptr_d;
    logic [W_ID-1:0]    out_id_q, out_id_d;
    logic               out_last_q, out_last_d;
    logic [W_CNT-1:0]   cnt_q, cnt_d;
    logic               err_loop_q, err_loop_d;

    logic [W_PTR-1:0]   start_a [N_REQ];
    logic               grant_vld_c;
    logic [W_ID-1:0]    grant_id_c;
    logic [W_ID-1:0]    cand_c;
    logic [W_PTR-1:0]   start_c;
    logic [W_PTR-1:0]   start_nxt_c;
    logic [W_PTR-1:0]   nxt_c;
    logic [W_PTR-1:0]   nxt2_c;
    logic               accept_c;
    logic [N_REQ-1:0]   req_rdy_c;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign start_a[g] = bus.req_start[g*W_PTR +: W_PTR];
    end

    // Table writes land at the edge, so same-cycle lookups see the old entry.
    always_comb begin
        tbl_d = tbl_q;
        if (bus.tbl_we) begin
            tbl_d[bus.tbl_addr] = bus.tbl_data;
        end
    end

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        cand_c      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand_c = W_ID'((32'(rr_q) + k) % N_REQ);
            if (!grant_vld_c && bus.req_vld[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = cand_c;
            end
        end
    end

    assign start_c     = start_a[grant_id_c];
    assign start_nxt_c = tbl_q[start_c];
    assign nxt_c       = tbl_q[out_ptr_q];
    assign nxt2_c      = tbl_q[nxt_c];

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        out_vld_d  = out_vld_q;
        out_ptr_d  = out_ptr_q;
        out_id_d   = out_id_q;
        out_last_d = out_last_q;
        cnt_d      = cnt_q;
        err_loop_d = 1'b0;
        accept_c   = 1'b0;
        req_rdy_c  = '0;

        case (state_q)
            ST_IDLE: begin
                accept_c = grant_vld_c;
            end
            ST_WALK: begin
                // out_vld is always high here, so out_rdy alone is the handshake.
                if (bus.out_rdy) begin
                    if (!out_last_q) begin
                        if (cnt_q == W_CNT'(N)) begin
                            err_loop_d = 1'b1;
                            out_vld_d  = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            out_ptr_d  = nxt_c;
                            out_last_d = (nxt2_c == '0);
                            cnt_d      = cnt_q + W_CNT'(1);
                        end
                    end else begin
                        out_vld_d = 1'b0;
                        state_d   = ST_IDLE;
`ifdef LIST_WALK_B2B_EN
                        accept_c  = grant_vld_c;
`endif
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                out_vld_d = 1'b0;
            end
        endcase

        // A granted start of 0 is consumed without producing a beat.
        if (accept_c) begin
            req_rdy_c = N_REQ'(1) << grant_id_c;
            rr_d      = W_ID'((32'(grant_id_c) + 32'd1) % N_REQ);
            if (start_c != '0) begin
                state_d    = ST_WALK;
                out_vld_d  = 1'b1;
                out_ptr_d  = start_c;
                out_id_d   = grant_id_c;
                out_last_d = (start_nxt_c == '0);
                cnt_d      = W_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            tbl_q      <= '{default: '0};
            out_vld_q  <= 1'b0;
            out_ptr_q  <= '0;
            out_id_q   <= '0;
            out_last_q <= 1'b0;
            cnt_q      <= '0;
            err_loop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            tbl_q      <= tbl_d;
            out_vld_q  <= out_vld_d;
            out_ptr_q  <= out_ptr_d;
            out_id_q   <= out_id_d;
            out_last_q <= out_last_d;
            cnt_q      <= cnt_d;
            err_loop_q <= err_loop_d;
        end
    end

    assign bus.req_rdy  = req_rdy_c;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_ptr  = out_ptr_q;
    assign bus.out_id   = out_id_q;
    assign bus.out_last = out_last_q;
    assign bus.err_loop = err_loop_q;
endmodule
